memory_operand_fetch: RTL and testbench
=======================================

Name: memory_operand_fetch

Overview:
- Pipeline stage directly after address calculation.
- Accepts an instruction bundle with up to two computed source memory addresses and issues 64-bit read requests to the data-memory port over a req/ack bus.
- Replaces the register operand value with the loaded data, then presents the bundle to execute through a valid/ready output register.
- Back-pressures address calculation while reads are outstanding.

Parameters:
- DATA_W, 64, width of operand values and memory read data.
- ADDR_W, 64, width of memory addresses.
- TIMEOUT, 255, cycles to wait for a response before flagging a bus error; range 1..255.

Ports:
- clk  input  1  clock; all logic samples on the rising edge.
- reset  input  1  synchronous reset, active-low: 0 resets the block at a rising edge of clk.
- inValid  input  1  upstream bundle valid.
- inReady  output  1  block can accept a bundle this cycle.
- isMemoryAccessSrc1In  input  1  source 1 is a memory operand.
- isMemoryAccessSrc2In  input  1  source 2 is a memory operand.
- memoryAddressSrc1In  input  ADDR_W  source 1 address.
- memoryAddressSrc2In  input  ADDR_W  source 2 address.
- operand1ValIn  input  DATA_W  register value for source 1.
- operand2ValIn  input  DATA_W  register value for source 2.
- opcodeIn  input  8  passed through unchanged.
- destRegIn  input  4  passed through unchanged.
- memReqValid  output  1  read request valid.
- memReqAddr  output  ADDR_W  read address.
- memReqReady  input  1  memory accepts the request.
- memRespValid  input  1  read data valid.
- memRespData  input  DATA_W  read data.
- outValid  output  1  bundle valid to execute.
- outReady  input  1  execute accepts the bundle.
- operand1ValOut  output  DATA_W  final source 1 value.
- operand2ValOut  output  DATA_W  final source 2 value.
- opcodeOut  output  8  registered opcode.
- destRegOut  output  4  registered destination register.
- busErrorOut  output  1  sticky; set on response timeout.

Behaviour:
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, OUT.
- Reset (reset=0 at a clock edge), taking effect from any state including mid-transaction:
  - state=IDLE, outValid=0, memReqValid=0, busErrorOut=0, wait counter=0.
  - All data output registers cleared to 0.
  - An in-flight response arriving after reset is ignored, because IDLE does not sample memRespValid.
- inReady = (state==IDLE) && reset==1. It is combinational from state only, not from outReady.
- Accept: in IDLE with inValid=1, register all inputs. Next state:
  - REQ1 if src1 is a memory operand;
  - else REQ2 if src2 is a memory operand;
  - else OUT, giving a 1-cycle pass-through latency.
- REQ1 / REQ2:
  - Assert memReqValid with memReqAddr set to the src1 or src2 address.
  - Hold both stable until memReqReady=1 is sampled.
  - Then go to WAIT1 / WAIT2 and clear the wait counter.
- WAIT1:
  - On memRespValid=1, operand1 register ← memRespData.
  - Next state is REQ2 if src2 is a memory operand, else OUT.
- WAIT2: on memRespValid=1, operand2 register ← memRespData; next state OUT.
- Response in the same cycle as the request acceptance: not allowed. A response is only sampled in the WAIT states.
- Timeout:
  - The counter increments each WAIT cycle without a response.
  - When it reaches TIMEOUT: set busErrorOut, leave that operand unchanged, and proceed as if a response had arrived.
  - busErrorOut clears only on reset.
- OUT:
  - outValid=1; outputs are held stable while outReady=0.
  - On outReady=1: outValid←0 and state←IDLE. No new bundle is accepted in that same cycle, so throughput is at most one bundle per 2 cycles.
- Both sources as memory operands: two sequential reads, src1 first. The same address is still read twice; there is no merging.
- Non-memory operands pass operandNValIn through unchanged.
- Latency, accept to outValid, with zero-wait memory (ack in the request cycle, response the next cycle):
  - no memory operand: 1 cycle;
  - one memory operand: 3 cycles;
  - two memory operands: 5 cycles.

Test Plan:
- No memory operands, opcode 0x01, operand1ValIn=5, operand2ValIn=7, outReady=1 → outValid rises 1 cycle after accept with 5/7; zero memReq cycles.
- Src1 memory at 0x1000, memory returns 0xDEADBEEF one cycle after ack → memReqAddr=0x1000 for exactly one cycle; operand1ValOut=0xDEADBEEF; operand2ValOut unchanged; outValid 3 cycles after accept.
- Both sources memory (0x2000, 0x2008), memReqReady held 0 for 3 cycles on each request → memReqValid and memReqAddr stable during the stall; src1 requested before src2; both operands loaded; inReady=0 throughout.
- Execute stall: outReady=0 for 4 cycles in OUT, then 1 → outValid and all outputs stable for 4 cycles; inReady=0; IDLE on the next edge.
- Timeout with TIMEOUT=4: no response → busErrorOut=1 after 4 WAIT cycles; the bundle is still delivered with the original operand1; busErrorOut stays 1 until reset.
- Reset asserted (reset=0) during WAIT2, then a stray memRespValid → all outputs zero; state IDLE; the stray response causes no change; inReady=1 once reset=1.

Source files
------------

// File: rtl/memory_operand_fetch.sv
// Operand fetch stage: loads up to two memory source operands over a req/ack
// read port, then hands the completed bundle to execute via a valid/ready register.
module memory_operand_fetch #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic              isMemoryAccessSrc1In,
  input  logic              isMemoryAccessSrc2In,
  input  logic [ADDR_W-1:0] memoryAddressSrc1In,
  input  logic [ADDR_W-1:0] memoryAddressSrc2In,
  input  logic [DATA_W-1:0] operand1ValIn,
  input  logic [DATA_W-1:0] operand2ValIn,
  input  logic [7:0]        opcodeIn,
  input  logic [3:0]        destRegIn,
  output logic              memReqValid,
  output logic [ADDR_W-1:0] memReqAddr,
  input  logic              memReqReady,
  input  logic              memRespValid,
  input  logic [DATA_W-1:0] memRespData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] operand1ValOut,
  output logic [DATA_W-1:0] operand2ValOut,
  output logic [7:0]        opcodeOut,
  output logic [3:0]        destRegOut,
  output logic              busErrorOut,
  output logic [2:0]        fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; a valid side holds its payload stable until that edge.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    OUT   = 3'd5
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t              state, state_next;
  logic                mem1, mem2;
  logic [ADDR_W-1:0]   addr1, addr2;
  logic [DATA_W-1:0]   op1, op2;
  logic [7:0]          opcode;
  logic [3:0]          dest;
  logic [7:0]          wait_cnt;
  logic                bus_error;
  logic                timed_out;

  assign timed_out = (wait_cnt == LAST_WAIT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (inValid) begin
               if (isMemoryAccessSrc1In)      state_next = REQ1;
               else if (isMemoryAccessSrc2In) state_next = REQ2;
               else                           state_next = OUT;
             end
      REQ1:  if (memReqReady) state_next = WAIT1;
      WAIT1: if (memRespValid || timed_out) state_next = mem2 ? REQ2 : OUT;
      REQ2:  if (memReqReady) state_next = WAIT2;
      WAIT2: if (memRespValid || timed_out) state_next = OUT;
      OUT:   if (outReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem1      <= 1'b0;
      mem2      <= 1'b0;
      addr1     <= '0;
      addr2     <= '0;
      op1       <= '0;
      op2       <= '0;
      opcode    <= '0;
      dest      <= '0;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (inValid) begin
          mem1   <= isMemoryAccessSrc1In;
          mem2   <= isMemoryAccessSrc2In;
          addr1  <= memoryAddressSrc1In;
          addr2  <= memoryAddressSrc2In;
          op1    <= operand1ValIn;
          op2    <= operand2ValIn;
          opcode <= opcodeIn;
          dest   <= destRegIn;
        end
        REQ1, REQ2: if (memReqReady) wait_cnt <= '0;
        // A timeout keeps the register value and moves on as if answered.
        WAIT1: begin
          if (memRespValid)   op1       <= memRespData;
          else if (timed_out) bus_error <= 1'b1;
          else                wait_cnt  <= wait_cnt + 8'd1;
        end
        WAIT2: begin
          if (memRespValid)   op2       <= memRespData;
          else if (timed_out) bus_error <= 1'b1;
          else                wait_cnt  <= wait_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign inReady        = (state == IDLE) && reset;
  assign memReqValid    = (state == REQ1) || (state == REQ2);
  assign memReqAddr     = (state == REQ2) ? addr2 : addr1;
  assign outValid       = (state == OUT);
  assign operand1ValOut = op1;
  assign operand2ValOut = op2;
  assign opcodeOut      = opcode;
  assign destRegOut     = dest;
  assign busErrorOut    = bus_error;
  assign fsm_state      = state;

endmodule

// File: tb/tb_memory_operand_fetch.sv
// Directed bench for memory_operand_fetch: a bench-side memory responder and an
// expected-bundle queue checked as each bundle leaves the stage.
module tb_memory_operand_fetch;

  localparam int EW = 140;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT2 = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, inReady;
  logic        isMemoryAccessSrc1In, isMemoryAccessSrc2In;
  logic [63:0] memoryAddressSrc1In, memoryAddressSrc2In;
  logic [63:0] operand1ValIn, operand2ValIn;
  logic [7:0]  opcodeIn;
  logic [3:0]  destRegIn;
  logic        memReqValid;
  logic [63:0] memReqAddr;
  logic        memReqReady, memRespValid;
  logic [63:0] memRespData;
  logic        outValid, outReady;
  logic [63:0] operand1ValOut, operand2ValOut;
  logic [7:0]  opcodeOut;
  logic [3:0]  destRegOut;
  logic        busErrorOut;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [EW-1:0] exp_q[$];

  memory_operand_fetch #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .isMemoryAccessSrc1In(isMemoryAccessSrc1In), .isMemoryAccessSrc2In(isMemoryAccessSrc2In),
    .memoryAddressSrc1In(memoryAddressSrc1In), .memoryAddressSrc2In(memoryAddressSrc2In),
    .operand1ValIn(operand1ValIn), .operand2ValIn(operand2ValIn),
    .opcodeIn(opcodeIn), .destRegIn(destRegIn),
    .memReqValid(memReqValid), .memReqAddr(memReqAddr), .memReqReady(memReqReady),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .outValid(outValid), .outReady(outReady),
    .operand1ValOut(operand1ValOut), .operand2ValOut(operand2ValOut),
    .opcodeOut(opcodeOut), .destRegOut(destRegOut),
    .busErrorOut(busErrorOut), .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input logic [EW-1:0] e, input logic err);
    check("op1", operand1ValOut, e[139:76]);
    check("op2", operand2ValOut, e[75:12]);
    check("opcode", {56'd0, opcodeOut}, {56'd0, e[11:4]});
    check("dest", {60'd0, destRegOut}, {60'd0, e[3:0]});
    check("bus_error", {63'd0, busErrorOut}, {63'd0, err});
    check("out_valid_hold", {63'd0, outValid}, 64'd1);
  endtask

  task automatic drive(input logic m1, input logic m2, input logic [63:0] a1, input logic [63:0] a2,
                       input logic [63:0] v1, input logic [63:0] v2, input logic [7:0] opc,
                       input logic [3:0] dst, input logic [63:0] e1, input logic [63:0] e2);
    int n = 0;
    while (!inReady && n < 50) begin @(negedge clk); n++; end
    check("in_ready", {63'd0, inReady}, 64'd1);
    isMemoryAccessSrc1In = m1;
    isMemoryAccessSrc2In = m2;
    memoryAddressSrc1In  = a1;
    memoryAddressSrc2In  = a2;
    operand1ValIn        = v1;
    operand2ValIn        = v2;
    opcodeIn             = opc;
    destRegIn            = dst;
    inValid              = 1'b1;
    t_acc                = cyc;
    exp_q.push_back({e1, e2, opc, dst});
    @(negedge clk);
    inValid = 1'b0;
    operand1ValIn = 64'(~v1);
    operand2ValIn = 64'(~v2);
  endtask

  task automatic serve_req(input logic [63:0] addr, input int stall, input logic [63:0] data,
                           input logic respond);
    int n = 0;
    while (!memReqValid && n < 50) begin @(negedge clk); n++; end
    check("req_valid", {63'd0, memReqValid}, 64'd1);
    check("req_addr", memReqAddr, addr);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("req_valid_stall", {63'd0, memReqValid}, 64'd1);
      check("req_addr_stall", memReqAddr, addr);
      check("in_ready_busy", {63'd0, inReady}, 64'd0);
    end
    memReqReady = 1'b1;
    @(negedge clk);
    memReqReady = 1'b0;
    check("req_drop", {63'd0, memReqValid}, 64'd0);
    if (respond) begin
      memRespValid = 1'b1;
      memRespData  = data;
      @(negedge clk);
      memRespValid = 1'b0;
      memRespData  = $urandom();
    end
  endtask

  task automatic wait_out(input int exp_lat, input int stall_out, input logic err);
    int n = 0;
    logic [EW-1:0] e;
    while (!outValid && n < 50) begin @(negedge clk); n++; end
    check("out_valid", {63'd0, outValid}, 64'd1);
    check("latency", 64'(cyc - t_acc), 64'(exp_lat));
    check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
    e = exp_q.pop_front();
    for (int i = 0; i < stall_out; i++) begin
      check_fields(e, err);
      check("in_ready_out", {63'd0, inReady}, 64'd0);
      @(negedge clk);
    end
    check_fields(e, err);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    check("out_drop", {63'd0, outValid}, 64'd0);
    check("idle_state", {61'd0, fsm_state}, {61'd0, S_IDLE});
    check("in_ready_idle", {63'd0, inReady}, 64'd1);
  endtask

  task automatic check_cleared(input logic rdy);
    check("rst_out_valid", {63'd0, outValid}, 64'd0);
    check("rst_req_valid", {63'd0, memReqValid}, 64'd0);
    check("rst_req_addr", memReqAddr, 64'd0);
    check("rst_op1", operand1ValOut, 64'd0);
    check("rst_op2", operand2ValOut, 64'd0);
    check("rst_opcode", {56'd0, opcodeOut}, 64'd0);
    check("rst_dest", {60'd0, destRegOut}, 64'd0);
    check("rst_bus_error", {63'd0, busErrorOut}, 64'd0);
    check("rst_state", {61'd0, fsm_state}, {61'd0, S_IDLE});
    check("rst_in_ready", {63'd0, inReady}, {63'd0, rdy});
  endtask

  initial begin
    logic [63:0] r1, r2, d1, d2;
    reset = 1'b0; inValid = 1'b0; outReady = 1'b0;
    isMemoryAccessSrc1In = 1'b0; isMemoryAccessSrc2In = 1'b0;
    memoryAddressSrc1In = '0; memoryAddressSrc2In = '0;
    operand1ValIn = '0; operand2ValIn = '0; opcodeIn = '0; destRegIn = '0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
    repeat (3) @(negedge clk);
    check_cleared(1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_cleared(1'b1);

    // pass-through, no memory operand
    drive(1'b0, 1'b0, 64'h9000, 64'h9008, 64'd5, 64'd7, 8'h01, 4'd3, 64'd5, 64'd7);
    check("no_mem_req", {63'd0, memReqValid}, 64'd0);
    wait_out(1, 0, 1'b0);

    // src1 from memory, zero-wait
    r2 = {32'd0, $urandom()};
    drive(1'b1, 1'b0, 64'h1000, 64'h1008, 64'h1234, r2, 8'h22, 4'd5, 64'hDEADBEEF, r2);
    serve_req(64'h1000, 0, 64'hDEADBEEF, 1'b1);
    wait_out(3, 0, 1'b0);

    // both from memory, 3-cycle request stalls
    d1 = {$urandom(), $urandom()};
    d2 = {$urandom(), $urandom()};
    drive(1'b1, 1'b1, 64'h2000, 64'h2008, 64'h11, 64'h22, 8'h33, 4'd7, d1, d2);
    serve_req(64'h2000, 3, d1, 1'b1);
    serve_req(64'h2008, 3, d2, 1'b1);
    wait_out(11, 0, 1'b0);

    // same address twice, zero-wait, then execute stall of 4 cycles
    d1 = {$urandom(), $urandom()};
    d2 = {$urandom(), $urandom()};
    drive(1'b1, 1'b1, 64'h2400, 64'h2400, 64'h1, 64'h2, 8'h44, 4'd9, d1, d2);
    serve_req(64'h2400, 0, d1, 1'b1);
    serve_req(64'h2400, 0, d2, 1'b1);
    wait_out(5, 4, 1'b0);

    // timeout on src1: operand kept, bus error sticky
    r1 = {$urandom(), $urandom()};
    drive(1'b1, 1'b0, 64'h3000, 64'h0, r1, 64'h77, 8'h55, 4'd1, r1, 64'h77);
    serve_req(64'h3000, 0, 64'h0, 1'b0);
    wait_out(6, 0, 1'b1);

    // src2 only, bus error still set
    d2 = {$urandom(), $urandom()};
    drive(1'b0, 1'b1, 64'h0, 64'h4000, 64'h66, 64'h99, 8'h66, 4'd2, 64'h66, d2);
    serve_req(64'h4000, 0, d2, 1'b1);
    wait_out(3, 0, 1'b1);

    // reset in WAIT2, then a stray response
    d1 = {$urandom(), $urandom()};
    drive(1'b1, 1'b1, 64'h5000, 64'h5008, 64'h3, 64'h4, 8'h77, 4'd4, d1, 64'h0);
    serve_req(64'h5000, 0, d1, 1'b1);
    serve_req(64'h5008, 0, 64'h0, 1'b0);
    check("in_wait2", {61'd0, fsm_state}, {61'd0, S_WAIT2});
    reset = 1'b0;
    @(negedge clk);
    check_cleared(1'b0);
    reset = 1'b1;
    memRespValid = 1'b1;
    memRespData  = 64'hBAD0BAD0;
    @(negedge clk);
    memRespValid = 1'b0;
    check_cleared(1'b1);
    void'(exp_q.pop_front());

    // normal operation after reset
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'hA, 64'hB, 8'h88, 4'd6, 64'hA, 64'hB);
    wait_out(1, 0, 1'b0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
